riscv_mul_result_stage: RTL and testbench

//  Downstream of the sequential unsigned shift-add multiplier. Captures its 64-bit

---
 rtl/riscv_mul_result_stage.sv | 181 ++++++++++++++++++
 tb/tb_riscv_mul_result_stage.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mul_result_stage.sv
// -----------------------------------------------------------------------------
// riscv_mul_result_stage
//
// Result stage behind the sequential unsigned shift-add multiplier. When the
// multiplier pulses done, the 64-bit unsigned product and the operands are
// captured. The RV32M signed corrections are applied to the high word over two
// cycles, and one 32-bit result (MUL / MULH / MULHSU / MULHU) is offered to
// writeback with a valid/ready handshake. EX is stalled while a result is in
// flight.
//
// Ports:
//   clk_i             in   1       clock, rising edge
//   rst_i             in   1       asynchronous, active-high reset
//   mul_done_i        in   1       1-cycle pulse: mul_res_i holds final product
//   mul_res_i         in   2*XLEN  unsigned product {hi,lo}
//   id_ra_value_r     in   XLEN    operand A
//   id_rb_value_r     in   XLEN    operand B
//   id_a_signed_r     in   1       A is signed (MULH, MULHSU)
//   id_b_signed_r     in   1       B is signed (MULH)
//   id_mul_sel_r      in   2       00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   wb_ready_i        in   1       writeback accepts the result this cycle
//   mul_wb_valid_o    out  1       result valid
//   mul_wb_data_o     out  XLEN    selected, sign-corrected result
//   ex_stall_mulres_w out  1       EX stall, high whenever the FSM is not idle
//
// Configuration macro:
//   MULRES_FAST_LO_EN  when defined, MUL (sel 00) skips the correction cycles
//                      and goes straight from IDLE to OUT.
// -----------------------------------------------------------------------------
module riscv_mul_result_stage #(
  parameter int XLEN = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mul_done_i,
  input  logic [2*XLEN-1:0] mul_res_i,
  input  logic [XLEN-1:0]   id_ra_value_r,
  input  logic [XLEN-1:0]   id_rb_value_r,
  input  logic              id_a_signed_r,
  input  logic              id_b_signed_r,
  input  logic [1:0]        id_mul_sel_r,
  input  logic              wb_ready_i,
  output logic              mul_wb_valid_o,
  output logic [XLEN-1:0]   mul_wb_data_o,
  output logic              ex_stall_mulres_w
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_CORR_A = 2'b01,
    ST_CORR_B = 2'b10,
    ST_OUT    = 2'b11
  } state_t;

  state_t            state_r, state_s;
  logic [XLEN-1:0]   hi_r, hi_s;
  logic [XLEN-1:0]   lo_r, lo_s;
  logic [XLEN-1:0]   a_r, a_s;
  logic [XLEN-1:0]   b_r, b_s;
  logic              a_sgn_r, a_sgn_s;
  logic              b_sgn_r, b_sgn_s;
  logic [1:0]        sel_r, sel_s;
  logic              valid_r, valid_s;
  logic [XLEN-1:0]   data_r, data_s;
  logic              stall_r, stall_s;

  // State and datapath registers; outputs are driven straight from flops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
      hi_r    <= {XLEN{1'b0}};
      lo_r    <= {XLEN{1'b0}};
      a_r     <= {XLEN{1'b0}};
      b_r     <= {XLEN{1'b0}};
      a_sgn_r <= 1'b0;
      b_sgn_r <= 1'b0;
      sel_r   <= 2'b00;
      valid_r <= 1'b0;
      data_r  <= {XLEN{1'b0}};
      stall_r <= 1'b0;
    end else begin
      state_r <= state_s;
      hi_r    <= hi_s;
      lo_r    <= lo_s;
      a_r     <= a_s;
      b_r     <= b_s;
      a_sgn_r <= a_sgn_s;
      b_sgn_r <= b_sgn_s;
      sel_r   <= sel_s;
      valid_r <= valid_s;
      data_r  <= data_s;
      stall_r <= stall_s;
    end
  end

  // Next-state, correction arithmetic and next output values.
  // Signed high word = unsigned high word - (A<0 ? B : 0) - (B<0 ? A : 0),
  // applied one term per cycle; the low word is identical in all cases.
  always_comb begin
    state_s = state_r;
    hi_s    = hi_r;
    lo_s    = lo_r;
    a_s     = a_r;
    b_s     = b_r;
    a_sgn_s = a_sgn_r;
    b_sgn_s = b_sgn_r;
    sel_s   = sel_r;
    valid_s = valid_r;
    data_s  = data_r;

    case (state_r)
      ST_IDLE: begin
        if (mul_done_i) begin
          hi_s    = mul_res_i[2*XLEN-1:XLEN];
          lo_s    = mul_res_i[XLEN-1:0];
          a_s     = id_ra_value_r;
          b_s     = id_rb_value_r;
          a_sgn_s = id_a_signed_r;
          b_sgn_s = id_b_signed_r;
          sel_s   = id_mul_sel_r;
`ifdef MULRES_FAST_LO_EN
          if (id_mul_sel_r == 2'b00) begin
            state_s = ST_OUT;
            valid_s = 1'b1;
            data_s  = mul_res_i[XLEN-1:0];
          end else begin
            state_s = ST_CORR_A;
          end
`else
          state_s = ST_CORR_A;
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CORR_A: begin
        if (a_sgn_r & a_r[XLEN-1]) begin
          hi_s = hi_r - b_r;
        end else begin
          hi_s = hi_r;
        end
        state_s = ST_CORR_B;
      end
      ST_CORR_B: begin
        if (b_sgn_r & b_r[XLEN-1]) begin
          hi_s = hi_r - a_r;
        end else begin
          hi_s = hi_r;
        end
        // Output word is chosen here so it is already registered in OUT.
        if (sel_r == 2'b00) begin
          data_s = lo_r;
        end else begin
          data_s = hi_s;
        end
        valid_s = 1'b1;
        state_s = ST_OUT;
      end
      ST_OUT: begin
        if (wb_ready_i) begin
          valid_s = 1'b0;
          state_s = ST_IDLE;
        end else begin
          valid_s = 1'b1;
          state_s = ST_OUT;
        end
      end
      default: begin
        valid_s = 1'b0;
        state_s = ST_IDLE;
      end
    endcase

    stall_s = (state_s != ST_IDLE);
  end

  assign mul_wb_valid_o    = valid_r;
  assign mul_wb_data_o     = data_r;
  assign ex_stall_mulres_w = stall_r;

endmodule

// File: tb/tb_riscv_mul_result_stage.sv
module tb_riscv_mul_result_stage;

  logic        clk;
  logic        rst;
  logic        done;
  logic [63:0] res;
  logic [31:0] ra;
  logic [31:0] rb;
  logic        a_sgn;
  logic        b_sgn;
  logic [1:0]  sel;
  logic        ready;
  logic        valid;
  logic [31:0] data;
  logic        stall;

  int tests;
  int failed;

  riscv_mul_result_stage #(.XLEN(32)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .mul_done_i       (done),
    .mul_res_i        (res),
    .id_ra_value_r    (ra),
    .id_rb_value_r    (rb),
    .id_a_signed_r    (a_sgn),
    .id_b_signed_r    (b_sgn),
    .id_mul_sel_r     (sel),
    .wb_ready_i       (ready),
    .mul_wb_valid_o   (valid),
    .mul_wb_data_o    (data),
    .ex_stall_mulres_w(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result: extend each operand per its sign flag to 64 bits and
  // multiply modulo 2^64; MUL takes the low half, the others the high half.
  function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                             input logic as, input logic bs, input logic [1:0] s);
    logic [63:0] ea, eb, p;
    ea = as ? {{32{a[31]}}, a} : {32'd0, a};
    eb = bs ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    return (s == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic int latency(input logic [1:0] s);
`ifdef MULRES_FAST_LO_EN
    return (s == 2'b00) ? 1 : 3;
`else
    return 3;
`endif
  endfunction

  // Behavioural model: one result in flight, visible after its latency,
  // retired on the first ready while visible. Checked every cycle.
  bit          m_pend;
  int          m_cnt;
  logic [31:0] m_res;
  bit          chk_en;

  always @(posedge clk) begin
    if (rst) begin
      m_pend = 1'b0;
    end else if (m_pend) begin
      if (m_cnt > 0) m_cnt = m_cnt - 1;
      else if (ready) m_pend = 1'b0;
    end else if (done) begin
      m_pend = 1'b1;
      m_res  = ref_result(ra, rb, a_sgn, b_sgn, sel);
      m_cnt  = latency(sel) - 1;
    end
    #1;
    if (chk_en) begin
      chk("cyc_valid", {31'd0, valid}, {31'd0, (m_pend && m_cnt == 0)});
      chk("cyc_stall", {31'd0, stall}, {31'd0, m_pend});
      if (m_pend && m_cnt == 0) chk("cyc_data", data, m_res);
    end
  end

  // Pulse done with the given operation; return cycles until valid (cycle 0 = pulse).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic as,
                        input logic bs, input logic [1:0] s, output int lat);
    @(negedge clk);
    ra = a; rb = b; a_sgn = as; b_sgn = bs; sel = s;
    res = {32'd0, a} * {32'd0, b};
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    lat = 1;
    while (!valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom % 5)
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  int lat;
  logic [31:0] a_v, b_v;

  initial begin
    tests = 0; failed = 0; chk_en = 1'b0;
    m_pend = 1'b0; m_cnt = 0; m_res = 32'd0;
    rst = 1'b1; done = 1'b0; res = 64'd0; ra = 32'd0; rb = 32'd0;
    a_sgn = 1'b0; b_sgn = 1'b0; sel = 2'b00; ready = 1'b1;
    #1;
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_data", data, 32'd0);
    chk("reset_stall", {31'd0, stall}, 32'd0);

    // Pin the reference model against hand-computed values.
    chk("pin_mul", ref_result(32'd3, 32'd5, 1'b0, 1'b0, 2'b00), 32'h0000_000F);
    chk("pin_mulh", ref_result(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 2'b01), 32'h0000_0000);
    chk("pin_mulhsu", ref_result(32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0, 2'b10), 32'hFFFF_FFFF);
    chk("pin_mulhu", ref_result(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 2'b11), 32'hFFFF_FFFE);

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // 1: MUL 3*5, one beat
    run_op(32'd3, 32'd5, 1'b0, 1'b0, 2'b00, lat);
    chk("t1_latency", lat, latency(2'b00));
    chk("t1_data", data, 32'h0000_000F);
    @(negedge clk);
    chk("t1_one_beat", {31'd0, valid}, 32'd0);

    // 2: MULH -1*-1
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 2'b01, lat);
    chk("t2_latency", lat, 32'd3);
    chk("t2_data", data, 32'h0000_0000);
    @(negedge clk);

    // 3: MULHSU -2*3
    run_op(32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0, 2'b10, lat);
    chk("t3_data", data, 32'hFFFF_FFFF);
    @(negedge clk);

    // 4: MULHU with writeback backpressure and an ignored done pulse
    ready = 1'b0;
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 2'b11, lat);
    chk("t4_latency", lat, 32'd3);
    for (int i = 0; i < 4; i++) begin
      chk("t4_hold_valid", {31'd0, valid}, 32'd1);
      chk("t4_hold_data", data, 32'hFFFF_FFFE);
      chk("t4_hold_stall", {31'd0, stall}, 32'd1);
      if (i == 1) begin
        ra = 32'd3; rb = 32'd5; sel = 2'b00; a_sgn = 1'b0; b_sgn = 1'b0;
        res = 64'd15; done = 1'b1;
      end else begin
        done = 1'b0;
      end
      @(negedge clk);
    end
    done = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    chk("t4_accepted", {31'd0, valid}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_no_ghost", {31'd0, valid}, 32'd0);
    end

    // 5: reset during CORR_A aborts the result
    @(negedge clk);
    ra = 32'h1234_5678; rb = 32'h9ABC_DEF0; a_sgn = 1'b1; b_sgn = 1'b1; sel = 2'b01;
    res = {32'd0, ra} * {32'd0, rb};
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5_valid", {31'd0, valid}, 32'd0);
    chk("t5_data", data, 32'd0);
    chk("t5_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t5_no_valid", {31'd0, valid}, 32'd0);
    end

    // 6: MUL 7*6, then MULH in the same build
    run_op(32'd7, 32'd6, 1'b0, 1'b0, 2'b00, lat);
    chk("t6_mul_latency", lat, latency(2'b00));
    chk("t6_mul_data", data, 32'h0000_002A);
    @(negedge clk);
    run_op(32'd7, 32'hFFFF_FFFA, 1'b1, 1'b1, 2'b01, lat);
    chk("t6_mulh_latency", lat, 32'd3);
    chk("t6_mulh_data", data, 32'hFFFF_FFFF);
    @(negedge clk);

    // Randomized traffic: done pulses at any time, random backpressure.
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      a_v = pick_operand();
      b_v = pick_operand();
      ra = a_v; rb = b_v;
      sel = 2'($urandom % 4);
      case (sel)
        2'b01:   begin a_sgn = 1'b1; b_sgn = 1'b1; end
        2'b10:   begin a_sgn = 1'b1; b_sgn = 1'b0; end
        2'b11:   begin a_sgn = 1'b0; b_sgn = 1'b0; end
        default: begin a_sgn = 1'($urandom % 2); b_sgn = 1'($urandom % 2); end
      endcase
      if ($urandom % 8 == 0) begin
        a_sgn = 1'($urandom % 2);
        b_sgn = 1'($urandom % 2);
      end
      res = {32'd0, a_v} * {32'd0, b_v};
      done = ($urandom % 3 == 0);
      ready = ($urandom % 4 != 0);
    end
    @(negedge clk);
    done = 1'b0;
    ready = 1'b1;
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
